// File: rtl/vend_pkg.sv
// ---------------------------------------------------------------------------
// vend_pkg
// Purpose : shared definitions for the vending machine product-select path
//           (product-select decoder, product-select encoder, vend controller).
// Contents:
//   N_SEL_DEFAULT - default number of product buttons
//   sel_state_t   - product-select encoder FSM states
// ---------------------------------------------------------------------------
package vend_pkg;

  localparam int N_SEL_DEFAULT = 8;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HOLD    = 2'd1,
    S_RELEASE = 2'd2
  } sel_state_t;

endpackage

// File: rtl/btn_sync_debounce.sv
// ---------------------------------------------------------------------------
// btn_sync_debounce
// Purpose : brings raw asynchronous button levels into the clk domain with a
//           two-flop synchronizer per bit, and optionally debounces each bit.
// Config  : macro VEND_DEBOUNCE_EN enables the per-bit debounce counters;
//           without it btn_f is the synchronized vector itself.
// Ports   :
//   clk    in  1      system clock, rising edge
//   rst_n  in  1      asynchronous active-low reset
//   btn_i  in  WIDTH  raw button levels, asynchronous to clk
//   btn_f  out WIDTH  synchronized (and optionally debounced) levels
// ---------------------------------------------------------------------------
module btn_sync_debounce #(
  parameter int WIDTH      = 8,
  parameter int DEB_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] btn_i,
  output logic [WIDTH-1:0] btn_f
);

  // Elaboration-time guard on the debounce length.
  if (DEB_CYCLES < 1) begin : g_bad_deb_cycles
    $error("btn_sync_debounce: DEB_CYCLES must be >= 1");
  end

  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] btn_s;

  // Two-flop synchronizer; the first stage may go metastable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      btn_s  <= '0;
    end else begin
      sync_q <= btn_i;
      btn_s  <= sync_q;
    end
  end

`ifdef VEND_DEBOUNCE_EN
  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [CW-1:0]    cnt_q [WIDTH];
  logic [WIDTH-1:0] filt_q;

  // A bit's filtered level follows the synchronized level only after the two
  // have disagreed for DEB_CYCLES consecutive clocks; any agreement (bounce
  // back) clears that bit's count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
      filt_q <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (btn_s[i] != filt_q[i]) begin
          if (cnt_q[i] == CNT_LAST) begin
            filt_q[i] <= btn_s[i];
            cnt_q[i]  <= '0;
          end else begin
            cnt_q[i] <= cnt_q[i] + CNT_ONE;
          end
        end else begin
          cnt_q[i] <= '0;
        end
      end
    end
  end

  assign btn_f = filt_q;
`else
  assign btn_f = btn_s;
`endif

endmodule

// File: rtl/product_sel_encoder.sv
// ---------------------------------------------------------------------------
// product_sel_encoder
// Purpose : converts the one-hot product button lines into a binary product
//           code, one code per press, handed to the vend controller over a
//           valid/ready interface. Multi-press is rejected with a one-cycle
//           multi_err pulse; a held button never repeats.
// Config  : macro VEND_DEBOUNCE_EN adds DEB_CYCLES of per-bit debounce in
//           front of the FSM (see btn_sync_debounce).
// Ports   :
//   clk        in  1      system clock, rising edge
//   rst_n      in  1      asynchronous active-low reset
//   btn_i      in  N_SEL  raw button levels, 1 = pressed
//   sel_ready  in  1      consumer accepts the code this cycle
//   sel_valid  out 1      sel_code holds a valid selection
//   sel_code   out W      binary index of the pressed button
//   multi_err  out 1      one-cycle pulse when >1 button seen at capture
//   busy       out 1      high in HOLD or RELEASE
// ---------------------------------------------------------------------------
module product_sel_encoder
  import vend_pkg::*;
#(
  parameter  int N_SEL      = N_SEL_DEFAULT,
  parameter  int DEB_CYCLES = 4,
  localparam int W          = $clog2(N_SEL)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_SEL-1:0] btn_i,
  input  logic             sel_ready,
  output logic             sel_valid,
  output logic [W-1:0]     sel_code,
  output logic             multi_err,
  output logic             busy
);

  if ((N_SEL < 2) || ((1 << W) != N_SEL)) begin : g_bad_n_sel
    $error("product_sel_encoder: N_SEL must be a power of 2 and >= 2");
  end

  localparam logic [N_SEL-1:0] VEC_ONE = N_SEL'(1);

  // Index of the set bit; only meaningful when exactly one bit is set.
  function automatic logic [W-1:0] onehot_to_bin(input logic [N_SEL-1:0] v);
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < N_SEL; k++) begin
      if (v[k]) begin
        r = r | W'(k);
      end
    end
    return r;
  endfunction

  logic [N_SEL-1:0] btn_f;
  logic             any_pressed;
  logic             multi_pressed;

  sel_state_t       state_q, state_d;
  logic             valid_q, valid_d;
  logic [W-1:0]     code_q, code_d;
  logic             err_q, err_d;

  btn_sync_debounce #(
    .WIDTH      (N_SEL),
    .DEB_CYCLES (DEB_CYCLES)
  ) u_btn_sync_debounce (
    .clk   (clk),
    .rst_n (rst_n),
    .btn_i (btn_i),
    .btn_f (btn_f)
  );

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign any_pressed   = |btn_f;
  assign multi_pressed = |(btn_f & (btn_f - VEC_ONE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      valid_q <= 1'b0;
      code_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      code_q  <= code_d;
      err_q   <= err_d;
    end
  end

  // Capture happens only from IDLE; presses seen in HOLD or RELEASE are
  // dropped. RELEASE waits for every button to be up, so a held button
  // produces exactly one transfer.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    code_d  = code_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (any_pressed) begin
          if (multi_pressed) begin
            err_d   = 1'b1;
            state_d = S_RELEASE;
          end else begin
            code_d  = onehot_to_bin(btn_f);
            valid_d = 1'b1;
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (valid_q && sel_ready) begin
          valid_d = 1'b0;
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (!any_pressed) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  assign sel_valid = valid_q;
  assign sel_code  = code_q;
  assign multi_err = err_q;
  assign busy      = (state_q == S_HOLD) || (state_q == S_RELEASE);

endmodule

// File: tb/tb_product_sel_encoder.sv
// ---------------------------------------------------------------------------
// tb_product_sel_encoder
// Purpose : self-checking bench for product_sel_encoder. Expected codes are
//           queued when a press is driven and popped by a monitor whenever a
//           valid/ready transfer occurs. Build with VEND_DEBOUNCE_EN defined
//           to exercise the debounce path as well.
// ---------------------------------------------------------------------------
module tb_product_sel_encoder;

  localparam int N_SEL = 8;
  localparam int W     = 3;
  localparam int DEB   = 4;
`ifdef VEND_DEBOUNCE_EN
  localparam int LAT = 3 + DEB;
`else
  localparam int LAT = 3;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N_SEL-1:0] btn_i;
  logic             sel_ready;
  logic             sel_valid;
  logic [W-1:0]     sel_code;
  logic             multi_err;
  logic             busy;

  int checks    = 0;
  int failures  = 0;
  int transfers = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_exp;

  always #5 clk = ~clk;

  product_sel_encoder #(
    .N_SEL      (N_SEL),
    .DEB_CYCLES (DEB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_i     (btn_i),
    .sel_ready (sel_ready),
    .sel_valid (sel_valid),
    .sel_code  (sel_code),
    .multi_err (multi_err),
    .busy      (busy)
  );

  // Scoreboard monitor: a transfer happens at the next rising edge whenever
  // valid and ready are both high mid-cycle.
  always @(negedge clk) begin
    if (rst_n && sel_valid && sel_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpected_transfer: got code %0d, expected no transfer", sel_code);
      end else begin
        mon_exp = exp_q.pop_front();
        transfers++;
        if (sel_code !== mon_exp) begin
          failures++;
          $display("[TB] FAIL transfer_code: got %0d expected %0d", sel_code, mon_exp);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_valid(input string name);
    int c;
    c = 0;
    while (sel_valid !== 1'b1 && c < 60) begin
      tick();
      c++;
    end
    checks++;
    if (sel_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL %s_valid_timeout: got sel_valid=%b expected 1 within 60 cycles", name, sel_valid);
    end
  endtask

  task automatic wait_idle(input string name);
    int c;
    c = 0;
    while (busy !== 1'b0 && c < 60) begin
      tick();
      c++;
    end
    checks++;
    if (busy !== 1'b0 || sel_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL %s_idle_timeout: got busy=%b sel_valid=%b expected 0/0", name, busy, sel_valid);
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    btn_i     = 8'hFF;
    sel_ready = 1'b0;
    tick(3);
    checks++;
    if (sel_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %b expected 0", sel_valid); end
    checks++;
    if (sel_code !== 3'd0) begin failures++; $display("[TB] FAIL reset_code: got %0d expected 0", sel_code); end
    checks++;
    if (multi_err !== 1'b0) begin failures++; $display("[TB] FAIL reset_err: got %b expected 0", multi_err); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    rst_n = 1'b1;
    btn_i = 8'h00;
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++;
      if (sel_valid !== 1'b0 || busy !== 1'b0 || multi_err !== 1'b0) begin
        failures++;
        $display("[TB] FAIL post_reset_idle: got valid=%b busy=%b err=%b expected 0/0/0", sel_valid, busy, multi_err);
      end
    end
  endtask

  task automatic test_single_press();
    sel_ready = 1'b1;
    btn_i     = 8'b0010_0000;
    exp_q.push_back(3'd5);
    for (int c = 1; c <= LAT; c++) begin
      tick();
      checks++;
      if (sel_valid !== (c == LAT)) begin
        failures++;
        $display("[TB] FAIL single_latency: cycle %0d got valid=%b expected %b", c, sel_valid, (c == LAT));
      end
    end
    checks++;
    if (sel_code !== 3'd5) begin failures++; $display("[TB] FAIL single_code: got %0d expected 5", sel_code); end
    tick();
    checks++;
    if (sel_valid !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL single_accept: got valid=%b busy=%b expected 0/1", sel_valid, busy);
    end
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++;
      if (sel_valid !== 1'b0) begin failures++; $display("[TB] FAIL single_no_repeat: got valid=%b expected 0", sel_valid); end
    end
    btn_i = 8'h00;
    wait_idle("single");
  endtask

  task automatic test_backpressure();
    int t0;
    t0        = transfers;
    sel_ready = 1'b0;
    btn_i     = 8'h01;
    exp_q.push_back(3'd0);
    tick(LAT);
    checks++;
    if (sel_valid !== 1'b1 || sel_code !== 3'd0) begin
      failures++;
      $display("[TB] FAIL bp_capture: got valid=%b code=%0d expected 1/0", sel_valid, sel_code);
    end
    for (int i = 0; i < 10; i++) begin
      if (i == 3) btn_i = 8'h80;
      tick();
      checks++;
      if (sel_valid !== 1'b1 || sel_code !== 3'd0) begin
        failures++;
        $display("[TB] FAIL bp_stable: cycle %0d got valid=%b code=%0d expected 1/0", i, sel_valid, sel_code);
      end
    end
    sel_ready = 1'b1;
    tick();
    checks++;
    if (sel_valid !== 1'b0) begin failures++; $display("[TB] FAIL bp_accept: got valid=%b expected 0", sel_valid); end
    tick(5);
    btn_i = 8'h00;
    wait_idle("bp");
    checks++;
    if (transfers - t0 !== 1) begin
      failures++;
      $display("[TB] FAIL bp_transfer_count: got %0d expected 1", transfers - t0);
    end
  endtask

  task automatic test_multi_press();
    int errs;
    int vals;
    errs      = 0;
    vals      = 0;
    sel_ready = 1'b1;
    btn_i     = 8'b1000_0100;
    for (int c = 1; c <= LAT + 6; c++) begin
      tick();
      if (multi_err === 1'b1) errs++;
      if (sel_valid === 1'b1) vals++;
      if (c == LAT) begin
        checks++;
        if (multi_err !== 1'b1) begin failures++; $display("[TB] FAIL multi_err_timing: got %b expected 1 at cycle %0d", multi_err, c); end
      end
    end
    checks++;
    if (errs !== 1) begin failures++; $display("[TB] FAIL multi_err_pulse: got %0d cycles expected 1", errs); end
    checks++;
    if (vals !== 0) begin failures++; $display("[TB] FAIL multi_no_valid: got %0d valid cycles expected 0", vals); end
    checks++;
    if (busy !== 1'b1) begin failures++; $display("[TB] FAIL multi_busy: got %b expected 1", busy); end
    btn_i = 8'h00;
    wait_idle("multi_release");
    btn_i = 8'h08;
    exp_q.push_back(3'd3);
    wait_valid("multi_next");
    checks++;
    if (sel_code !== 3'd3) begin failures++; $display("[TB] FAIL multi_next_code: got %0d expected 3", sel_code); end
    tick();
    btn_i = 8'h00;
    wait_idle("multi_next");
  endtask

  task automatic test_release_repress();
    int t0;
    t0        = transfers;
    sel_ready = 1'b1;
    btn_i     = 8'h02;
    exp_q.push_back(3'd1);
    wait_valid("repress_first");
    tick();
    btn_i = 8'h00;
    tick();
    btn_i = 8'h40;
    exp_q.push_back(3'd6);
    wait_valid("repress_second");
    tick();
    btn_i = 8'h00;
    wait_idle("repress");
    checks++;
    if (transfers - t0 !== 2) begin
      failures++;
      $display("[TB] FAIL repress_transfer_count: got %0d expected 2", transfers - t0);
    end
  endtask

`ifdef VEND_DEBOUNCE_EN
  task automatic test_debounce();
    sel_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      btn_i = (i % 2 == 0) ? 8'h04 : 8'h00;
      tick(2);
      checks++;
      if (sel_valid !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("[TB] FAIL deb_bounce: got valid=%b busy=%b expected 0/0", sel_valid, busy);
      end
    end
    btn_i = 8'h04;
    exp_q.push_back(3'd2);
    for (int c = 1; c <= LAT; c++) begin
      tick();
      checks++;
      if (sel_valid !== (c == LAT)) begin
        failures++;
        $display("[TB] FAIL deb_latency: cycle %0d got valid=%b expected %b", c, sel_valid, (c == LAT));
      end
    end
    checks++;
    if (sel_code !== 3'd2) begin failures++; $display("[TB] FAIL deb_code: got %0d expected 2", sel_code); end
    tick();
    btn_i = 8'h00;
    wait_idle("deb");
  endtask
`endif

  task automatic test_reset_mid_hold();
    sel_ready = 1'b0;
    btn_i     = 8'h10;
    wait_valid("midhold");
    tick(2);
    btn_i = 8'h00;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (sel_valid !== 1'b0 || busy !== 1'b0 || sel_code !== 3'd0) begin
      failures++;
      $display("[TB] FAIL midhold_async_reset: got valid=%b busy=%b code=%0d expected 0/0/0", sel_valid, busy, sel_code);
    end
    tick(2);
    rst_n = 1'b1;
    sel_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++;
      if (sel_valid !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("[TB] FAIL midhold_after: got valid=%b busy=%b expected 0/0", sel_valid, busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_backpressure();
    test_multi_press();
    test_release_repress();
`ifdef VEND_DEBOUNCE_EN
    test_debounce();
`endif
    test_reset_mid_hold();
    checks++;
    if (exp_q.size() !== 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending codes expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
